mem_request_arbiter: RTL and testbench

Shares the single block-wide memory controller between the instruction-cache and data-cache miss paths. It accepts one block request at a time from either requester and issues it to the controller as a one-cycle request strobe. It then waits for the controller's block-complete indication and returns the block, with a one-cycle done pulse, to the requester that owns the transaction. It sits between the two L1 caches and the memory controller, in the core clock domain.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_select.sv | 34 +++
 rtl/mem_request_arbiter.sv | 111 +++++++++++
 tb/tb_mem_request_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the I/D memory request arbiter.
package mem_arb_pkg;

    localparam int ADDRESS_SIZE = 64;
    localparam int BLOCK_SIZE   = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } mem_arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } mem_arb_owner_t;

endpackage

// File: rtl/mem_arb_select.sv
// Picks the winning requester when the arbiter is idle.
// MEM_ARB_ROUND_ROBIN_EN selects alternating priority; otherwise the data side always wins.
module mem_arb_select
    import mem_arb_pkg::*;
(
    input  logic           i_req,
    input  logic           d_req,
    input  mem_arb_owner_t last_owner,
    output mem_arb_owner_t winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        winner = OWNER_D;
        if (i_req && d_req) begin
            // Whoever was not served last goes next.
            winner = (last_owner == OWNER_D) ? OWNER_I : OWNER_D;
        end else if (i_req) begin
            winner = OWNER_I;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = (last_owner == OWNER_D);

    always_comb begin
        winner = OWNER_D;
        if (i_req && !d_req) begin
            winner = OWNER_I;
        end
    end
`endif

endmodule

// File: rtl/mem_request_arbiter.sv
// Shares one block memory controller between the I-cache and D-cache miss paths.
// Priority scheme is chosen by MEM_ARB_ROUND_ROBIN_EN (see mem_arb_select).
//
// Handshake: each requester holds its req level until its one-cycle done pulse;
// the controller sees a single-cycle requestEnable_o and completes on a 0->1 edge
// of blockOutEnable_i observed while waiting.
module mem_request_arbiter
    import mem_arb_pkg::*;
#(
    parameter int addressSize = ADDRESS_SIZE,
    parameter int blockSize   = BLOCK_SIZE
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   iReq_i,
    input  logic [addressSize-1:0] iAddress_i,
    input  logic                   dReq_i,
    input  logic [addressSize-1:0] dAddress_i,
    input  logic [blockSize-1:0]   dData_i,
    input  logic                   dIsWrite_i,
    output logic                   iGrant_o,
    output logic                   dGrant_o,
    output logic                   iDone_o,
    output logic                   dDone_o,
    output logic [blockSize-1:0]   block_o,
    output logic [addressSize-1:0] address_o,
    output logic [blockSize-1:0]   data_o,
    output logic                   requestEnable_o,
    output logic                   isMemWrite_o,
    input  logic [blockSize-1:0]   block_i,
    input  logic                   blockOutEnable_i,
    input  logic                   isMemoryEngaged_i,
    output mem_arb_state_t         debug_state
);

    mem_arb_state_t         state;
    mem_arb_state_t         next_state;
    mem_arb_owner_t         owner;
    mem_arb_owner_t         winner;
    logic [addressSize-1:0] addr_q;
    logic [blockSize-1:0]   data_q;
    logic                   write_q;
    logic [blockSize-1:0]   block_q;
    logic                   boe_prev;
    logic                   take;
    logic                   boe_rise;

    // The owner register doubles as the last-served record for round-robin.
    mem_arb_select u_select (
        .i_req      (iReq_i),
        .d_req      (dReq_i),
        .last_owner (owner),
        .winner     (winner)
    );

    assign take     = (state == IDLE) && (iReq_i || dReq_i) && !isMemoryEngaged_i;
    assign boe_rise = blockOutEnable_i && !boe_prev;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (take) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (boe_rise) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state    <= IDLE;
            owner    <= OWNER_I;
            addr_q   <= '0;
            data_q   <= '0;
            write_q  <= 1'b0;
            block_q  <= '0;
            boe_prev <= 1'b0;
        end else begin
            state    <= next_state;
            boe_prev <= blockOutEnable_i;
            if (take) begin
                owner <= winner;
                if (winner == OWNER_D) begin
                    addr_q  <= dAddress_i;
                    data_q  <= dData_i;
                    write_q <= dIsWrite_i;
                end else begin
                    addr_q  <= iAddress_i;
                    data_q  <= '0;
                    write_q <= 1'b0;
                end
            end
            if ((state == WAIT) && boe_rise) begin
                block_q <= block_i;
            end
        end
    end

    assign iGrant_o        = (state != IDLE) && (owner == OWNER_I);
    assign dGrant_o        = (state != IDLE) && (owner == OWNER_D);
    assign iDone_o         = (state == DONE) && (owner == OWNER_I);
    assign dDone_o         = (state == DONE) && (owner == OWNER_D);
    assign requestEnable_o = (state == ISSUE);
    assign address_o       = addr_q;
    assign data_o          = data_q;
    assign isMemWrite_o    = write_q;
    assign block_o         = block_q;
    assign debug_state     = state;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed self-checking bench for mem_request_arbiter (default or round-robin build).
module tb_mem_request_arbiter;
    import mem_arb_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_req;
    logic [63:0]    i_addr;
    logic           d_req;
    logic [63:0]    d_addr;
    logic [255:0]   d_data;
    logic           d_wr;
    logic           i_grant, d_grant, i_done, d_done;
    logic [255:0]   blk_out;
    logic [63:0]    addr_out;
    logic [255:0]   data_out;
    logic           req_en, mem_wr;
    logic [255:0]   blk_in;
    logic           boe;
    logic           engaged;
    mem_arb_state_t dbg_state;

    int checks = 0;
    int errors = 0;

    mem_request_arbiter dut (
        .clock_i           (clk),
        .reset_i           (rst),
        .iReq_i            (i_req),
        .iAddress_i        (i_addr),
        .dReq_i            (d_req),
        .dAddress_i        (d_addr),
        .dData_i           (d_data),
        .dIsWrite_i        (d_wr),
        .iGrant_o          (i_grant),
        .dGrant_o          (d_grant),
        .iDone_o           (i_done),
        .dDone_o           (d_done),
        .block_o           (blk_out),
        .address_o         (addr_out),
        .data_o            (data_out),
        .requestEnable_o   (req_en),
        .isMemWrite_o      (mem_wr),
        .block_i           (blk_in),
        .blockOutEnable_i  (boe),
        .isMemoryEngaged_i (engaged),
        .debug_state       (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " state"},   256'(dbg_state), 256'(IDLE));
        check({tag, " i_grant"}, 256'(i_grant), 256'd0);
        check({tag, " d_grant"}, 256'(d_grant), 256'd0);
        check({tag, " i_done"},  256'(i_done), 256'd0);
        check({tag, " d_done"},  256'(d_done), 256'd0);
        check({tag, " req_en"},  256'(req_en), 256'd0);
    endtask

    logic [255:0] blk_a5;
    logic [255:0] blk_c3;
    logic [255:0] blk_5a;
    logic [255:0] wdata;
    logic [3:0]   exp_d_order;

    initial begin
        blk_a5 = {32{8'hA5}};
        blk_c3 = {32{8'hC3}};
        blk_5a = {32{8'h5A}};
        wdata  = {16{16'h1234}};
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_d_order = 4'b0101;
`else
        exp_d_order = 4'b1111;
`endif
        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_addr = '0;
        d_data = '0; d_wr = 1'b0; blk_in = '0; boe = 1'b0; engaged = 1'b0;
        tick(); tick();

        // Reset values
        check_quiet("reset");
        check("reset addr", 256'(addr_out), 256'd0);
        check("reset data", data_out, 256'd0);
        check("reset block", blk_out, 256'd0);
        check("reset wr", 256'(mem_wr), 256'd0);

        // Instruction read at 0x1000, completion after 10 cycles
        rst = 1'b0; i_req = 1'b1; i_addr = 64'h1000;
        tick();
        check("i1 grant", 256'(i_grant), 256'd1);
        check("i1 d_grant", 256'(d_grant), 256'd0);
        check("i1 req_en", 256'(req_en), 256'd1);
        check("i1 addr", 256'(addr_out), 256'h1000);
        check("i1 wr", 256'(mem_wr), 256'd0);
        tick();
        check("i1 req_en once", 256'(req_en), 256'd0);
        check("i1 state wait", 256'(dbg_state), 256'(WAIT));
        repeat (8) tick();
        check("i1 no early done", 256'(i_done), 256'd0);
        blk_in = blk_a5; boe = 1'b1;
        tick();
        check("i1 done", 256'(i_done), 256'd1);
        check("i1 no d_done", 256'(d_done), 256'd0);
        check("i1 block", blk_out, blk_a5);
        check("i1 grant in done", 256'(i_grant), 256'd1);
        i_req = 1'b0;
        tick();
        check_quiet("i1 after");
        boe = 1'b0;
        tick();

        // Data write at 0x2040
        d_req = 1'b1; d_addr = 64'h2040; d_data = wdata; d_wr = 1'b1;
        tick();
        check("dw grant", 256'(d_grant), 256'd1);
        check("dw i_grant", 256'(i_grant), 256'd0);
        check("dw req_en", 256'(req_en), 256'd1);
        check("dw addr", 256'(addr_out), 256'h2040);
        check("dw data", data_out, wdata);
        check("dw wr", 256'(mem_wr), 256'd1);
        tick(); tick(); tick();
        check("dw no early done", 256'(d_done), 256'd0);
        blk_in = blk_5a; boe = 1'b1;
        tick();
        check("dw done", 256'(d_done), 256'd1);
        check("dw no i_done", 256'(i_done), 256'd0);
        d_req = 1'b0; d_wr = 1'b0; boe = 1'b0;
        tick();
        check_quiet("dw after");

        // blockOutEnable already high when WAIT is entered
        i_req = 1'b1; i_addr = 64'h3000; boe = 1'b1;
        tick();
        check("hold grant", 256'(i_grant), 256'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold no done", 256'(i_done), 256'd0);
            check("hold state", 256'(dbg_state), 256'(WAIT));
        end
        boe = 1'b0;
        tick();
        check("hold low no done", 256'(i_done), 256'd0);
        blk_in = blk_c3; boe = 1'b1;
        tick();
        check("hold done", 256'(i_done), 256'd1);
        check("hold block", blk_out, blk_c3);
        i_req = 1'b0;
        tick();
        check("hold single pulse", 256'(i_done), 256'd0);
        boe = 1'b0;
        tick();

        // Controller busy blocks the grant
        engaged = 1'b1; i_req = 1'b1; i_addr = 64'h3800;
        tick(); tick();
        check("busy no grant", 256'(i_grant), 256'd0);
        check("busy idle", 256'(dbg_state), 256'(IDLE));
        engaged = 1'b0;
        tick();
        check("busy then grant", 256'(i_grant), 256'd1);
        tick();
        boe = 1'b1;
        tick();
        check("busy done", 256'(i_done), 256'd1);
        i_req = 1'b0; boe = 1'b0;
        tick();

        // Data read: inputs change after grant, request dropped mid-WAIT
        d_req = 1'b1; d_addr = 64'h4000; d_wr = 1'b0; d_data = '0;
        tick();
        check("lat grant", 256'(d_grant), 256'd1);
        check("lat addr", 256'(addr_out), 256'h4000);
        d_addr = 64'hFFFF_0000; d_wr = 1'b1; d_data = wdata;
        tick();
        check("lat addr held", 256'(addr_out), 256'h4000);
        check("lat wr held", 256'(mem_wr), 256'd0);
        check("lat data held", data_out, 256'd0);
        d_req = 1'b0;
        tick(); tick();
        check("lat grant kept", 256'(d_grant), 256'd1);
        boe = 1'b1;
        tick();
        check("lat done", 256'(d_done), 256'd1);
        boe = 1'b0; d_wr = 1'b0;
        tick();
        check_quiet("lat after");

        // Reset while waiting abandons the transaction
        i_req = 1'b1; i_addr = 64'h5000;
        tick(); tick();
        check("rst in wait", 256'(dbg_state), 256'(WAIT));
        rst = 1'b1;
        tick();
        check_quiet("rst mid");
        check("rst mid addr", 256'(addr_out), 256'd0);
        check("rst mid block", blk_out, 256'd0);
        rst = 1'b0; i_req = 1'b0; boe = 1'b1;
        tick();
        check_quiet("rst late rise");
        tick();
        check_quiet("rst late rise 2");
        boe = 1'b0;

        // Both requests held from reset release for four transactions
        rst = 1'b1; i_req = 1'b1; d_req = 1'b1; i_addr = 64'h6000; d_addr = 64'h7000;
        tick();
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            check("both d_grant", 256'(d_grant), 256'(exp_d_order[t]));
            check("both i_grant", 256'(i_grant), 256'(!exp_d_order[t]));
            check("both addr", 256'(addr_out), exp_d_order[t] ? 256'h7000 : 256'h6000);
            tick();
            boe = 1'b1;
            tick();
            check("both d_done", 256'(d_done), 256'(exp_d_order[t]));
            check("both i_done", 256'(i_done), 256'(!exp_d_order[t]));
            boe = 1'b0;
            tick();
            check("both idle", 256'(dbg_state), 256'(IDLE));
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
